// File: rtl/axi_sram_bridge.sv
// axi_sram_bridge: converts the core's inst/data SRAM-like ports into one
// AXI3 master. Reads from both ports share the AR channel, and data wins
// arbitration. Stores are sequenced over AW/W/B. Each channel holds at most
// one latched request.
// Build option: define EARLY_WRITE_ACK_EN to acknowledge a store as soon as
// both AW and W have handshaked. In that build, a data read may pass a store
// whose B is still outstanding, provided the two words differ.
module axi_sram_bridge #(
  parameter logic [3:0] INST_ID = 4'd0,
  parameter logic [3:0] DATA_ID = 4'd1
) (
  input  logic        aclk,
  input  logic        aresetn,
  // instruction fetch port
  input  logic        inst_sram_req,
  input  logic        inst_sram_wr,
  input  logic [1:0]  inst_sram_size,
  input  logic [3:0]  inst_sram_wstrb,
  input  logic [31:0] inst_sram_addr,
  input  logic [31:0] inst_sram_wdata,
  output logic        inst_sram_addr_ok,
  output logic        inst_sram_data_ok,
  output logic [31:0] inst_sram_rdata,
  // data port
  input  logic        data_sram_req,
  input  logic        data_sram_wr,
  input  logic [1:0]  data_sram_size,
  input  logic [3:0]  data_sram_wstrb,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic        data_sram_addr_ok,
  output logic        data_sram_data_ok,
  output logic [31:0] data_sram_rdata,
  // AR channel
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic [1:0]  arlock,
  output logic [3:0]  arcache,
  output logic [2:0]  arprot,
  output logic        arvalid,
  input  logic        arready,
  // R channel
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready,
  // AW channel
  output logic [3:0]  awid,
  output logic [31:0] awaddr,
  output logic [7:0]  awlen,
  output logic [2:0]  awsize,
  output logic [1:0]  awburst,
  output logic [1:0]  awlock,
  output logic [3:0]  awcache,
  output logic [2:0]  awprot,
  output logic        awvalid,
  input  logic        awready,
  // W channel
  output logic [3:0]  wid,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wlast,
  output logic        wvalid,
  input  logic        wready,
  // B channel
  input  logic [3:0]  bid,
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready
);

  typedef enum logic {AR_IDLE, AR_SEND} ar_state_t;
  typedef enum logic [1:0] {W_IDLE, W_SEND, W_WAITB} w_state_t;

  ar_state_t   ar_state_q, ar_state_d;
  w_state_t    w_state_q, w_state_d;

  logic        inst_rd_pend, data_pend, wr_b_pend;
  logic        aw_done_q, aw_done_d, w_done_q, w_done_d;

  logic [31:0] ar_addr_q;
  logic [2:0]  ar_size_q;
  logic [3:0]  ar_id_q;
  logic [31:0] aw_addr_q;
  logic [2:0]  aw_size_q;
  logic [3:0]  w_strb_q;
  logic [31:0] w_data_q;

  logic        data_rd_grant, inst_rd_grant, store_accept;
  logic        write_issued, b_done, store_ok;
  logic        inst_r_ok, data_r_ok, rd_block_clear;

  // Request fields that are meaningless for a fetch, and R/B status the core
  // never sees.
  logic        unused;
  assign unused = &{1'b0, inst_sram_wr, inst_sram_wstrb, inst_sram_wdata,
                    rresp, rlast, bid, bresp};

  // Decide whether a data read may go out while a store awaits its B.
`ifdef EARLY_WRITE_ACK_EN
  assign rd_block_clear = !wr_b_pend || (data_sram_addr[31:2] != aw_addr_q[31:2]);
  assign store_ok       = write_issued;
`else
  assign rd_block_clear = !wr_b_pend;
  assign store_ok       = b_done;
`endif

  // R returns are routed by ID. They are gated by the pending flag, so a
  // response to a request dropped by reset is never reported.
  assign inst_r_ok = rvalid && (rid == INST_ID) && inst_rd_pend;
  assign data_r_ok = rvalid && (rid == DATA_ID) && data_pend;

  assign inst_sram_addr_ok = inst_rd_grant;
  assign data_sram_addr_ok = data_rd_grant | store_accept;
  assign inst_sram_data_ok = inst_r_ok;
  assign data_sram_data_ok = data_r_ok | store_ok;
  assign inst_sram_rdata   = rdata;
  assign data_sram_rdata   = rdata;

  assign rready  = 1'b1;
  assign bready  = 1'b1;

  assign arid    = ar_id_q;
  assign araddr  = ar_addr_q;
  assign arsize  = ar_size_q;
  assign arvalid = (ar_state_q == AR_SEND);
  assign arlen   = 8'd0;
  assign arburst = 2'b01;
  assign arlock  = 2'd0;
  assign arcache = 4'd0;
  assign arprot  = 3'd0;

  assign awid    = DATA_ID;
  assign awaddr  = aw_addr_q;
  assign awsize  = aw_size_q;
  assign awvalid = (w_state_q == W_SEND) && !aw_done_q;
  assign awlen   = 8'd0;
  assign awburst = 2'b01;
  assign awlock  = 2'd0;
  assign awcache = 4'd0;
  assign awprot  = 3'd0;

  assign wid     = DATA_ID;
  assign wdata   = w_data_q;
  assign wstrb   = w_strb_q;
  assign wlast   = 1'b1;
  assign wvalid  = (w_state_q == W_SEND) && !w_done_q;

  // AR arbitration: data reads have fixed priority over fetches, and only
  // one AR is in flight at a time.
  always_comb begin
    // NOTE: every signal this block writes gets a default first. Without the
    // defaults, a path that skips an assignment would infer a latch.
    ar_state_d    = ar_state_q;
    data_rd_grant = 1'b0;
    inst_rd_grant = 1'b0;
    case (ar_state_q)
      AR_IDLE: begin
        if (data_sram_req && !data_sram_wr && !data_pend && rd_block_clear) begin
          data_rd_grant = 1'b1;
          ar_state_d    = AR_SEND;
        end else if (inst_sram_req && !inst_rd_pend) begin
          inst_rd_grant = 1'b1;
          ar_state_d    = AR_SEND;
        end
      end
      AR_SEND: if (arready) ar_state_d = AR_IDLE;
      default: ar_state_d = AR_IDLE;
    endcase
  end

  // Store sequencing. AW and W retire independently, in either order, and
  // then the FSM waits for B.
  always_comb begin
    w_state_d    = w_state_q;
    aw_done_d    = aw_done_q;
    w_done_d     = w_done_q;
    store_accept = 1'b0;
    write_issued = 1'b0;
    b_done       = 1'b0;
    case (w_state_q)
      W_IDLE: begin
        if (data_sram_req && data_sram_wr && !data_pend && !wr_b_pend && !data_rd_grant) begin
          store_accept = 1'b1;
          aw_done_d    = 1'b0;
          w_done_d     = 1'b0;
          w_state_d    = W_SEND;
        end
      end
      W_SEND: begin
        if (awvalid && awready) aw_done_d = 1'b1;
        if (wvalid && wready)   w_done_d  = 1'b1;
        if (aw_done_d && w_done_d) begin
          write_issued = 1'b1;
          w_state_d    = W_WAITB;
        end
      end
      W_WAITB: begin
        if (bvalid) begin
          b_done    = 1'b1;
          w_state_d = W_IDLE;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  // State, outstanding flags and latched channel payloads.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      // NOTE: the few payload registers are reset along with the control
      // state. This keeps the AXI outputs free of X after reset, even though
      // the valids already qualify them.
      ar_state_q   <= AR_IDLE;
      w_state_q    <= W_IDLE;
      aw_done_q    <= 1'b0;
      w_done_q     <= 1'b0;
      inst_rd_pend <= 1'b0;
      data_pend    <= 1'b0;
      wr_b_pend    <= 1'b0;
      ar_addr_q    <= '0;
      ar_size_q    <= '0;
      ar_id_q      <= '0;
      aw_addr_q    <= '0;
      aw_size_q    <= '0;
      w_strb_q     <= '0;
      w_data_q     <= '0;
    end else begin
      // NOTE: non-blocking assignments, so every register here sees the
      // pre-edge value of every other register, whatever order the lines
      // are in.
      ar_state_q <= ar_state_d;
      w_state_q  <= w_state_d;
      aw_done_q  <= aw_done_d;
      w_done_q   <= w_done_d;

      if (inst_rd_grant)  inst_rd_pend <= 1'b1;
      else if (inst_r_ok) inst_rd_pend <= 1'b0;

      if (data_sram_addr_ok)         data_pend <= 1'b1;
      else if (data_r_ok || store_ok) data_pend <= 1'b0;

      if (store_accept) wr_b_pend <= 1'b1;
      else if (b_done)  wr_b_pend <= 1'b0;

      if (data_rd_grant) begin
        ar_addr_q <= data_sram_addr;
        ar_size_q <= {1'b0, data_sram_size};
        ar_id_q   <= DATA_ID;
      end else if (inst_rd_grant) begin
        ar_addr_q <= inst_sram_addr;
        ar_size_q <= {1'b0, inst_sram_size};
        ar_id_q   <= INST_ID;
      end

      if (store_accept) begin
        aw_addr_q <= data_sram_addr;
        aw_size_q <= {1'b0, data_sram_size};
        w_strb_q  <= data_sram_wstrb;
        w_data_q  <= data_sram_wdata;
      end
    end
  end

endmodule

// File: tb/tb_axi_sram_bridge.sv
// Testbench for axi_sram_bridge. Directed stimulus plays the AXI slave by
// hand. Expected read data and store acks go into scoreboard queues, and a
// negedge monitor pops them whenever a data_ok appears. Sections that depend
// on EARLY_WRITE_ACK_EN follow the same macro.
module tb_axi_sram_bridge;

  logic        aclk, aresetn;
  logic        inst_sram_req, inst_sram_wr;
  logic [1:0]  inst_sram_size;
  logic [3:0]  inst_sram_wstrb;
  logic [31:0] inst_sram_addr, inst_sram_wdata;
  logic        inst_sram_addr_ok, inst_sram_data_ok;
  logic [31:0] inst_sram_rdata;
  logic        data_sram_req, data_sram_wr;
  logic [1:0]  data_sram_size;
  logic [3:0]  data_sram_wstrb;
  logic [31:0] data_sram_addr, data_sram_wdata;
  logic        data_sram_addr_ok, data_sram_data_ok;
  logic [31:0] data_sram_rdata;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst, arlock;
  logic [3:0]  arcache;
  logic [2:0]  arprot;
  logic        arvalid, arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast, rvalid, rready;
  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst, awlock;
  logic [3:0]  awcache;
  logic [2:0]  awprot;
  logic        awvalid, awready;
  logic [3:0]  wid;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast, wvalid, wready;
  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid, bready;

  axi_sram_bridge dut (
    .aclk(aclk), .aresetn(aresetn),
    .inst_sram_req(inst_sram_req), .inst_sram_wr(inst_sram_wr),
    .inst_sram_size(inst_sram_size), .inst_sram_wstrb(inst_sram_wstrb),
    .inst_sram_addr(inst_sram_addr), .inst_sram_wdata(inst_sram_wdata),
    .inst_sram_addr_ok(inst_sram_addr_ok), .inst_sram_data_ok(inst_sram_data_ok),
    .inst_sram_rdata(inst_sram_rdata),
    .data_sram_req(data_sram_req), .data_sram_wr(data_sram_wr),
    .data_sram_size(data_sram_size), .data_sram_wstrb(data_sram_wstrb),
    .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
    .data_sram_addr_ok(data_sram_addr_ok), .data_sram_data_ok(data_sram_data_ok),
    .data_sram_rdata(data_sram_rdata),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
    .arburst(arburst), .arlock(arlock), .arcache(arcache), .arprot(arprot),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
    .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
    .awburst(awburst), .awlock(awlock), .awcache(awcache), .awprot(awprot),
    .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  typedef struct {
    logic [31:0] rdata;
    bit          is_store;
    bit          b_now;     // store ack expected in the same cycle as bvalid
  } data_exp_t;

  logic [31:0] inst_q[$];
  data_exp_t   data_q[$];
  int          checks   = 0;
  int          failures = 0;

`ifdef EARLY_WRITE_ACK_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic r_beat(input logic [3:0] id, input logic [31:0] d);
    rvalid = 1'b1;
    rid    = id;
    rdata  = d;
    step();
    rvalid = 1'b0;
  endtask

  // Monitor: every data_ok must match the oldest expectation for its port.
  always @(negedge aclk) begin
    if (inst_sram_data_ok) begin
      if (inst_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL inst_unexpected_data_ok rdata=%h expected=none", inst_sram_rdata);
      end else begin
        check("inst_rdata", inst_sram_rdata, inst_q.pop_front());
      end
    end
    if (data_sram_data_ok) begin
      if (data_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL data_unexpected_data_ok rdata=%h expected=none", data_sram_rdata);
      end else begin
        data_exp_t e;
        e = data_q.pop_front();
        if (e.is_store) check("store_ack_vs_bvalid", {31'd0, bvalid}, {31'd0, e.b_now});
        else            check("data_rdata", data_sram_rdata, e.rdata);
      end
    end
  end

  // Watchdog: every wait below is a fixed cycle count, but the run must
  // still end on its own if something stalls.
  initial begin
    #100000;
    failures++;
    $display("FAIL watchdog_timeout actual=running expected=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    int arv_cnt;
    aresetn = 1'b0;
    inst_sram_req = 0; inst_sram_wr = 0; inst_sram_size = 2'd2; inst_sram_wstrb = 0;
    inst_sram_addr = 0; inst_sram_wdata = 0;
    data_sram_req = 0; data_sram_wr = 0; data_sram_size = 2'd2; data_sram_wstrb = 0;
    data_sram_addr = 0; data_sram_wdata = 0;
    arready = 0; rid = 0; rdata = 0; rresp = 0; rlast = 1; rvalid = 0;
    awready = 0; wready = 0; bid = 0; bresp = 0; bvalid = 0;

    // Reset state
    repeat (3) step();
    aresetn = 1'b1;
    @(negedge aclk);
    check("rst_arvalid", {31'd0, arvalid}, 32'd0);
    check("rst_awvalid", {31'd0, awvalid}, 32'd0);
    check("rst_wvalid",  {31'd0, wvalid},  32'd0);
    check("rst_addr_ok", {30'd0, inst_sram_addr_ok, data_sram_addr_ok}, 32'd0);
    check("rst_data_ok", {30'd0, inst_sram_data_ok, data_sram_data_ok}, 32'd0);
    check("rst_ready",   {30'd0, rready, bready}, 32'd3);
    step();

    // Fetch with arready delayed by three cycles
    inst_sram_req = 1; inst_sram_addr = 32'h1C00_0000;
    @(negedge aclk);
    check("fetch_addr_ok", {31'd0, inst_sram_addr_ok}, 32'd1);
    step();
    inst_sram_req = 0;
    arv_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      arready = (i == 3);
      @(negedge aclk);
      if (arvalid) begin
        arv_cnt++;
        check("fetch_arid",   {28'd0, arid}, {28'd0, 4'd0});
        check("fetch_araddr", araddr, 32'h1C00_0000);
      end
      step();
    end
    arready = 0;
    check("fetch_arvalid_cycles", arv_cnt, 32'd4);
    check("fetch_arsize", {29'd0, arsize}, 32'd2);
    inst_q.push_back(32'h0280_0C21);
    r_beat(4'd0, 32'h0280_0C21);

    // Fetch and data read in the same cycle: data wins arbitration
    data_sram_req = 1; data_sram_wr = 0; data_sram_addr = 32'h0000_3000;
    inst_sram_req = 1; inst_sram_addr = 32'h1C00_0004;
    @(negedge aclk);
    check("arb_data_addr_ok", {31'd0, data_sram_addr_ok}, 32'd1);
    check("arb_inst_held",    {31'd0, inst_sram_addr_ok}, 32'd0);
    step();
    data_sram_req = 0; arready = 1;
    @(negedge aclk);
    check("arb_arid_data",   {28'd0, arid}, 32'd1);
    check("arb_araddr_data", araddr, 32'h0000_3000);
    check("arb_inst_wait",   {31'd0, inst_sram_addr_ok}, 32'd0);
    step();
    arready = 0;
    @(negedge aclk);
    check("arb_inst_addr_ok_after_hs", {31'd0, inst_sram_addr_ok}, 32'd1);
    step();
    inst_sram_req = 0; arready = 1;
    @(negedge aclk);
    check("arb_arid_inst",   {28'd0, arid}, 32'd0);
    check("arb_araddr_inst", araddr, 32'h1C00_0004);
    step();
    arready = 0;
    data_q.push_back('{rdata: 32'h1111_2222, is_store: 1'b0, b_now: 1'b0});
    r_beat(4'd1, 32'h1111_2222);
    inst_q.push_back(32'h3333_4444);
    r_beat(4'd0, 32'h3333_4444);

    // Store with W accepted before AW
    data_sram_req = 1; data_sram_wr = 1; data_sram_addr = 32'h0000_1000;
    data_sram_wstrb = 4'b0011; data_sram_wdata = 32'hDEAD_BEEF;
    @(negedge aclk);
    check("st_addr_ok", {31'd0, data_sram_addr_ok}, 32'd1);
    step();
    data_sram_req = 0; data_sram_wr = 0; wready = 1;
    @(negedge aclk);
    check("st_valids", {30'd0, awvalid, wvalid}, 32'd3);
    check("st_awaddr", awaddr, 32'h0000_1000);
    check("st_wdata",  wdata, 32'hDEAD_BEEF);
    check("st_wstrb",  {28'd0, wstrb}, 32'h3);
    check("st_ids_last", {awid, wid, 3'd0, wlast}, {4'd1, 4'd1, 4'd1});
    check("st_no_ack_yet", {31'd0, data_sram_data_ok}, 32'd0);
    step();
    wready = 0; awready = 1;
    data_sram_req = 1; data_sram_wr = 0; data_sram_addr = 32'h0000_2000;
    data_q.push_back('{rdata: 32'h0, is_store: 1'b1, b_now: !EARLY});
    @(negedge aclk);
    check("st_w_first", {30'd0, awvalid, wvalid}, 32'd2);
    check("st_load_held_pend", {31'd0, data_sram_addr_ok}, 32'd0);
    check("st_ack_at_hs", {31'd0, data_sram_data_ok}, {31'd0, EARLY});
    step();
    awready = 0;
    @(negedge aclk);
    check("st_valids_done", {30'd0, awvalid, wvalid}, 32'd0);
`ifdef EARLY_WRITE_ACK_EN
    // Different word: granted before B
    check("early_load_2000_ok", {31'd0, data_sram_addr_ok}, 32'd1);
    step();
    data_sram_req = 0; arready = 1;
    @(negedge aclk);
    check("early_araddr_2000", araddr, 32'h0000_2000);
    step();
    arready = 0;
    data_q.push_back('{rdata: 32'hAAAA_5555, is_store: 1'b0, b_now: 1'b0});
    r_beat(4'd1, 32'hAAAA_5555);
    // Same word as the pending store: stalls until B
    data_sram_req = 1; data_sram_addr = 32'h0000_1000;
    for (int i = 0; i < 2; i++) begin
      @(negedge aclk);
      check("early_load_1000_stall", {30'd0, data_sram_addr_ok, arvalid}, 32'd0);
      step();
    end
    bvalid = 1;
    @(negedge aclk);
    check("early_b_no_ack", {30'd0, data_sram_data_ok, data_sram_addr_ok}, 32'd0);
    step();
    bvalid = 0;
    @(negedge aclk);
    check("early_load_1000_after_b", {31'd0, data_sram_addr_ok}, 32'd1);
    step();
    data_sram_req = 0; arready = 1;
    step();
    arready = 0;
    data_q.push_back('{rdata: 32'h5555_AAAA, is_store: 1'b0, b_now: 1'b0});
    r_beat(4'd1, 32'h5555_AAAA);
`else
    // Any data read waits for B
    for (int i = 0; i < 3; i++) begin
      check("wb_load_blocked", {30'd0, data_sram_addr_ok, arvalid}, 32'd0);
      step();
      @(negedge aclk);
    end
    step();
    bvalid = 1;
    @(negedge aclk);
    check("wb_ack_on_b", {31'd0, data_sram_data_ok}, 32'd1);
    check("wb_load_still_held", {31'd0, data_sram_addr_ok}, 32'd0);
    step();
    bvalid = 0;
    @(negedge aclk);
    check("wb_load_after_b", {31'd0, data_sram_addr_ok}, 32'd1);
    step();
    data_sram_req = 0; arready = 1;
    @(negedge aclk);
    check("wb_araddr_2000", araddr, 32'h0000_2000);
    step();
    arready = 0;
    data_q.push_back('{rdata: 32'hCAFE_F00D, is_store: 1'b0, b_now: 1'b0});
    r_beat(4'd1, 32'hCAFE_F00D);
`endif

    // Reset in the middle of AR_SEND and W_SEND
    inst_sram_req = 1; inst_sram_addr = 32'h1C00_0100;
    data_sram_req = 1; data_sram_wr = 1; data_sram_addr = 32'h0000_4000;
    data_sram_wdata = 32'h0000_0001; data_sram_wstrb = 4'hF;
    @(negedge aclk);
    check("mid_addr_oks", {30'd0, inst_sram_addr_ok, data_sram_addr_ok}, 32'd3);
    step();
    inst_sram_req = 0; data_sram_req = 0; data_sram_wr = 0;
    @(negedge aclk);
    check("mid_valids_up", {29'd0, arvalid, awvalid, wvalid}, 32'd7);
    #2;
    aresetn = 1'b0;
    #1;
    check("mid_rst_valids", {29'd0, arvalid, awvalid, wvalid}, 32'd0);
    step();
    step();
    aresetn = 1'b1;
    rvalid = 1; rid = 4'd0; rdata = 32'hBAD0_0000;
    @(negedge aclk);
    check("stale_inst_r", {31'd0, inst_sram_data_ok}, 32'd0);
    step();
    rid = 4'd1; rdata = 32'hBAD0_0001;
    @(negedge aclk);
    check("stale_data_r", {31'd0, data_sram_data_ok}, 32'd0);
    step();
    rvalid = 0; bvalid = 1;
    @(negedge aclk);
    check("stale_b", {30'd0, data_sram_data_ok, arvalid}, 32'd0);
    step();
    bvalid = 0;
    repeat (2) step();

    check("inst_q_drained", inst_q.size(), 32'd0);
    check("data_q_drained", data_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
